thermometer_serial_decoder: RTL

//  Receive end of the serial thermometer link in the partial-product adder path.

---
 rtl/thermo_pkg.sv | 7 +
 rtl/thermometer_serial_decoder.sv | 78 +++++++
 2 files changed

// File: rtl/thermo_pkg.sv
// thermo_pkg: state encoding and frame-length helper shared by the thermometer link ends.
package thermo_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECEIVING = 2'd1, DONE = 2'd2} state_e;
  function automatic int thermo_len(input int n);
    return 2 ** n - 1;
  endfunction
endpackage

// File: rtl/thermometer_serial_decoder.sv
// thermometer_serial_decoder: counts leading ones of a serial thermometer frame and flags bubbles.
module thermometer_serial_decoder
  import thermo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         bit_valid,
  input  logic         serial_in,
  output logic [N-1:0] binary_out,
  output logic         done,
  output logic         error,
  output logic         busy
);
  localparam int TOTAL_BITS = thermo_len(N);
  localparam logic [N-1:0] LAST = N'(TOTAL_BITS - 1);
  state_e state_q, state_d;
  logic [N-1:0] bit_cnt_q, bit_cnt_d, ones_q, ones_d, binary_q, binary_d;
  logic seen_zero_q, seen_zero_d, bubble_q, bubble_d, error_q, error_d, done_q, done_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      seen_zero_q <= 1'b0;
      bubble_q    <= 1'b0;
      binary_q    <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      seen_zero_q <= seen_zero_d;
      bubble_q    <= bubble_d;
      binary_q    <= binary_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end
  // start wins in every state: arms from IDLE/DONE, aborts and restarts in RECEIVING
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    seen_zero_d = seen_zero_q;
    bubble_d    = bubble_q;
    binary_d    = binary_q;
    error_d     = error_q;
    done_d      = 1'b0;
    if (start) begin
      state_d     = RECEIVING;
      bit_cnt_d   = '0;
      ones_d      = '0;
      seen_zero_d = 1'b0;
      bubble_d    = 1'b0;
    end else if (state_q == RECEIVING && bit_valid) begin
      bit_cnt_d   = bit_cnt_q + 1'b1;
      seen_zero_d = seen_zero_q | ~serial_in;
      ones_d      = ones_q + N'(serial_in & ~seen_zero_q);
      bubble_d    = bubble_q | (serial_in & seen_zero_q);
      if (bit_cnt_q == LAST) begin
        binary_d = ones_d;
        error_d  = bubble_d;
        done_d   = 1'b1;
        state_d  = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  assign binary_out = binary_q;
  assign error      = error_q;
  assign done       = done_q;
  assign busy       = state_q == RECEIVING;
endmodule
